// File: rtl/batcharger_ctrl_p.sv
// Battery charger controller: trickle / constant-current / constant-voltage
// Moore FSM with temperature supervision, CV timeout and recharge.
// Optional feature macro: BATCHG_TC_TIMEOUT_EN
//   undefined -> trickle charge may last indefinitely, FAULT is unreachable
//   defined   -> trickle charge longer than TC_TICKS ticks latches FAULT
module batcharger_ctrl_p #(
    parameter int DW       = 8,
    parameter int TICK_CYC = 2040,
    parameter int TC_TICKS = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          vtok,
    input  logic [DW-1:0] vbat,
    input  logic [DW-1:0] ibat,
    input  logic [DW-1:0] tbat,
    input  logic [DW-1:0] vcutoff,
    input  logic [DW-1:0] vpreset,
    input  logic [DW-1:0] vrecharge,
    input  logic [DW-1:0] tempmin,
    input  logic [DW-1:0] tempmax,
    input  logic [DW-1:0] iend,
    input  logic [DW-1:0] tmax,
    inout  wire           dvdd,
    inout  wire           dgnd,
    output logic          tc,
    output logic          cc,
    output logic          cv,
    output logic          imonen,
    output logic          vmonen,
    output logic          tmonen,
    output logic          done,
    output logic          fault,
    output logic [2:0]    st
);

    // Prescaler width; a one-cycle tick still needs a 1-bit register.
    localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
    localparam logic [DW-1:0] TC_LIMIT   = DW'(TC_TICKS);
    localparam logic [DW-1:0] TICK_SAT   = {DW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TC     = 3'd1,
        ST_CC     = 3'd2,
        ST_CV     = 3'd3,
        ST_DONE   = 3'd4,
        ST_TFAULT = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    // Output vector order: tc cc cv imonen vmonen tmonen done fault st[2:0]
    localparam logic [10:0] OUT_IDLE = 11'b000_000_00_000;

    // Moore output decode of a state code.
    function automatic logic [10:0] decode_outputs(input state_t s);
        logic [10:0] o;
        case (s)
            ST_IDLE:   o = 11'b000_000_00_000;
            ST_TC:     o = 11'b100_111_00_001;
            ST_CC:     o = 11'b010_111_00_010;
            ST_CV:     o = 11'b001_111_00_011;
            ST_DONE:   o = 11'b000_010_10_100;
            ST_TFAULT: o = 11'b000_001_00_101;
`ifdef BATCHG_TC_TIMEOUT_EN
            ST_FAULT:  o = 11'b000_000_01_110;
`else
            ST_FAULT:  o = 11'b000_000_00_110;
`endif
            default:   o = 11'b000_000_00_000;
        endcase
        return o;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic [PW-1:0] presc_r;
    logic [DW-1:0] tick_cnt_r;
    logic [DW-1:0] ticks_eff_s;
    logic          active_s;
    logic          tick_s;
    logic          temp_ok_s;
    logic          cv_timeout_s;
    logic          tc_timeout_s;
    logic [10:0]   out_r;
    logic          unused_s;

    // Supply pins carry no logic; fold them away together with the
    // trickle limit, which is only consumed when the timeout is built in.
    assign unused_s = ^{dvdd, dgnd, TC_LIMIT};

    assign active_s  = en & vtok;
    assign tick_s    = active_s & (presc_r == PRESC_LAST);
    assign temp_ok_s = (tbat >= tempmin) && (tbat <= tempmax);

    // Tick count as it will be after this edge (saturating), so that a
    // timeout fires on the very edge the limit is reached.
    assign ticks_eff_s = (tick_s && (tick_cnt_r != TICK_SAT)) ?
                         (tick_cnt_r + DW'(1)) : tick_cnt_r;

    assign cv_timeout_s = (tmax != {DW{1'b0}}) && (ticks_eff_s >= tmax);

`ifdef BATCHG_TC_TIMEOUT_EN
    assign tc_timeout_s = (ticks_eff_s >= TC_LIMIT);
`else
    assign tc_timeout_s = 1'b0;
`endif

    // Next-state logic: enable first, then measurement-valid freeze, then
    // temperature supervision ahead of every charging transition.
    always_comb begin
        state_next_s = state_r;
        if (!en) begin
            state_next_s = ST_IDLE;
        end else if (!vtok) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!temp_ok_s) begin
                        state_next_s = ST_TFAULT;
                    end else if (vbat >= vpreset) begin
                        state_next_s = ST_DONE;
                    end else if (vbat >= vcutoff) begin
                        state_next_s = ST_CC;
                    end else begin
                        state_next_s = ST_TC;
                    end
                end
                ST_TC: begin
                    if (!temp_ok_s) begin
                        state_next_s = ST_TFAULT;
                    end else if (vbat >= vcutoff) begin
                        state_next_s = ST_CC;
                    end else if (tc_timeout_s) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_TC;
                    end
                end
                ST_CC: begin
                    if (!temp_ok_s) begin
                        state_next_s = ST_TFAULT;
                    end else if (vbat >= vpreset) begin
                        state_next_s = ST_CV;
                    end else begin
                        state_next_s = ST_CC;
                    end
                end
                ST_CV: begin
                    if (!temp_ok_s) begin
                        state_next_s = ST_TFAULT;
                    end else if ((ibat < iend) || cv_timeout_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CV;
                    end
                end
                ST_DONE: begin
                    if (!temp_ok_s) begin
                        state_next_s = ST_TFAULT;
                    end else if (vbat < vrecharge) begin
                        state_next_s = (vbat >= vcutoff) ? ST_CC : ST_TC;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end
                ST_TFAULT: begin
                    if (temp_ok_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_TFAULT;
                    end
                end
                ST_FAULT: begin
                    state_next_s = ST_FAULT;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Prescaler and tick counter: cleared on every state entry, frozen
    // whenever the charger is not actively measuring.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r    <= {PW{1'b0}};
            tick_cnt_r <= {DW{1'b0}};
        end else if (state_next_s != state_r) begin
            presc_r    <= {PW{1'b0}};
            tick_cnt_r <= {DW{1'b0}};
        end else if (active_s) begin
            presc_r    <= tick_s ? {PW{1'b0}} : (presc_r + PW'(1));
            tick_cnt_r <= ticks_eff_s;
        end else begin
            presc_r    <= presc_r;
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Output register, loaded with the decode of the state being entered
    // so outputs are flops yet track the state register edge for edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= OUT_IDLE;
        end else begin
            out_r <= decode_outputs(state_next_s);
        end
    end

    assign {tc, cc, cv, imonen, vmonen, tmonen, done, fault, st} = out_r;

endmodule
